sid_voice_scheduler: RTL and testbench

SID_VOICE_SCHEDULER -- requirements
Module: sid_voice_scheduler

---
 rtl/sid_pkg.sv | 18 +
 rtl/sid_rr_arbiter.sv | 28 ++
 rtl/sid_voice_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sid_voice_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared state encoding, defaults and helpers for sid_* blocks
package sid_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GATE = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    localparam int NREQ_DEF      = 4;
    localparam int TICK_LOG2_DEF = 16;
    localparam int REL_TICKS_DEF = 4;

    // Index width that stays legal for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sid_rr_arbiter.sv
// rtl/sid_rr_arbiter.sv - combinational round-robin picker starting after last grantee
module sid_rr_arbiter
    import sid_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [IDW-1:0]  winner_o,
    output logic            valid_o
);

    // Scan from farthest to nearest so the requester closest after last_i wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_i) + k) % NREQ;
            if (req_i[idx]) begin
                winner_o = IDW'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sid_voice_scheduler.sv
// rtl/sid_voice_scheduler.sv - shares one SID voice among NREQ note requesters
module sid_voice_scheduler
    import sid_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int TICK_LOG2 = TICK_LOG2_DEF,
    parameter int REL_TICKS = REL_TICKS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*16-1:0]          req_frequency,
    input  logic [NREQ*8-1:0]           req_duration,
    input  logic [NREQ*8-1:0]           req_attack,
    input  logic [NREQ*8-1:0]           req_sustain,
    input  logic [NREQ*8-1:0]           req_waveform,
    input  logic                        kill,
    output logic [15:0]                 frequency,
    output logic [7:0]                  duration,
    output logic [7:0]                  attack,
    output logic [7:0]                  sustain,
    output logic [7:0]                  waveform,
    output logic [NREQ-1:0]             ack,
    output logic [NREQ-1:0]             done,
    output logic                        busy,
    output logic [id_width(NREQ)-1:0]   gnt_id
);

    localparam int             IDW      = id_width(NREQ);
    localparam int             TW       = (TICK_LOG2 > 0) ? TICK_LOG2 : 1;
    localparam logic [TW-1:0]  TMAX     = (TICK_LOG2 > 0) ? {TW{1'b1}} : '0;
    localparam logic [7:0]     REL_LAST = 8'(REL_TICKS - 1);

    logic [1:0]      state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [15:0]     freq_q, freq_d;
    logic [7:0]      dur_q, dur_d;
    logic [7:0]      atk_q, atk_d;
    logic [7:0]      sus_q, sus_d;
    logic [7:1]      wave_q, wave_d;
    logic            gate_q, gate_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;

    logic [IDW-1:0]  arb_id;
    logic            arb_valid;
    logic            tick_wrap;

    sid_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (arb_id),
        .valid_o  (arb_valid)
    );

    assign tick_wrap = (tick_q == TMAX);

    // Next-state: note sequencing, tick/note counting, parameter latch, pulses.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        freq_d  = freq_q;
        dur_d   = dur_q;
        atk_d   = atk_q;
        sus_d   = sus_q;
        wave_d  = wave_q;
        ack_d   = '0;
        done_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    state_d       = S_LOAD;
                    gnt_d         = arb_id;
                    last_d        = arb_id;
                    freq_d        = req_frequency[16*arb_id +: 16];
                    dur_d         = req_duration[8*arb_id +: 8];
                    atk_d         = req_attack[8*arb_id +: 8];
                    sus_d         = req_sustain[8*arb_id +: 8];
                    wave_d        = req_waveform[8*arb_id+1 +: 7];
                    ack_d[arb_id] = 1'b1;
                end
            end
            S_LOAD: begin
                tick_d  = '0;
                cnt_d   = '0;
                state_d = (dur_q != 8'd0) ? S_GATE : S_REL;
            end
            S_GATE: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    if (cnt_q == dur_q - 8'd1) begin
                        state_d = S_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    tick_d = TW'(tick_q + 1'b1);
                end
            end
            S_REL: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    if (cnt_q == REL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    tick_d = TW'(tick_q + 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides sequencing; the pointer update from the grant stays.
        if (kill && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tick_d  = '0;
            cnt_d   = '0;
        end
        gate_d = (state_d == S_GATE);
        // Registered done lands exactly on the last REL cycle.
        if (state_d == S_REL && tick_d == TMAX && cnt_d == REL_LAST) begin
            done_d[gnt_d] = 1'b1;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            cnt_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            freq_q  <= '0;
            dur_q   <= '0;
            atk_q   <= '0;
            sus_q   <= '0;
            wave_q  <= '0;
            gate_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            freq_q  <= freq_d;
            dur_q   <= dur_d;
            atk_q   <= atk_d;
            sus_q   <= sus_d;
            wave_q  <= wave_d;
            gate_q  <= gate_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign frequency = freq_q;
    assign duration  = dur_q;
    assign attack    = atk_q;
    assign sustain   = sus_q;
    assign waveform  = {wave_q, gate_q};
    assign ack       = ack_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_sid_voice_scheduler.sv
// tb/tb_sid_voice_scheduler.sv - scoreboard bench for sid_voice_scheduler
module tb_sid_voice_scheduler;

    localparam int NREQ = 4;
    localparam int TL   = 2;
    localparam int RT   = 2;
    localparam int TPC  = 1 << TL;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*16-1:0]   req_frequency;
    logic [NREQ*8-1:0]    req_duration;
    logic [NREQ*8-1:0]    req_attack;
    logic [NREQ*8-1:0]    req_sustain;
    logic [NREQ*8-1:0]    req_waveform;
    logic                 kill;
    logic [15:0]          frequency;
    logic [7:0]           duration;
    logic [7:0]           attack;
    logic [7:0]           sustain;
    logic [7:0]           waveform;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [1:0]           gnt_id;

    typedef struct {
        int          id;
        logic [15:0] freq;
        logic [7:0]  wave;
    } grant_t;

    typedef struct {
        int id;
        int gate;
        int low;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    int checks   = 0;
    int errors   = 0;
    int ack_cnt  = 0;
    int done_cnt = 0;
    int gate_c   = 0;
    int low_c    = 0;
    int na       = 0;
    int nd       = 0;
    int lat;

    always #5 clk = ~clk;

    sid_voice_scheduler #(.NREQ(NREQ), .TICK_LOG2(TL), .REL_TICKS(RT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_frequency (req_frequency),
        .req_duration  (req_duration),
        .req_attack    (req_attack),
        .req_sustain   (req_sustain),
        .req_waveform  (req_waveform),
        .kill          (kill),
        .frequency     (frequency),
        .duration      (duration),
        .attack        (attack),
        .sustain       (sustain),
        .waveform      (waveform),
        .ack           (ack),
        .done          (done),
        .busy          (busy),
        .gnt_id        (gnt_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_note(input int i, input logic [15:0] f, input logic [7:0] d, input logic [7:0] w);
        req_frequency[16*i +: 16] = f;
        req_duration[8*i +: 8]    = d;
        req_attack[8*i +: 8]      = 8'(i + 8'h10);
        req_sustain[8*i +: 8]     = 8'(i + 8'h20);
        req_waveform[8*i +: 8]    = w;
    endtask

    task automatic expect_note(input int i, input int dur, input bit with_done);
        gq.push_back('{id: i, freq: req_frequency[16*i +: 16], wave: req_waveform[8*i +: 8]});
        na++;
        if (with_done) begin
            dq.push_back('{id: i, gate: dur * TPC, low: 1 + RT * TPC});
            nd++;
        end
    endtask

    task automatic wait_acks(input int target, input int bound, output int cycles);
        cycles = 0;
        while (ack_cnt < target && cycles < bound) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("ack_wait", ack_cnt, target);
    endtask

    task automatic wait_dones(input int target, input int bound);
        int t = 0;
        while (done_cnt < target && t < bound) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("done_wait", done_cnt, target);
    endtask

    // Scoreboard: pop expectations on every ack and done pulse.
    always @(negedge clk) begin
        grant_t g;
        done_t  d;
        if (rst_n) begin
            if (ack != '0) begin
                ack_cnt++;
                chk("ack_queued", gq.size() != 0, 1);
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    chk("ack_onehot", ack, 32'(1 << g.id));
                    chk("gnt_id", gnt_id, g.id);
                    chk("load_freq", frequency, g.freq);
                    chk("load_wave", waveform, g.wave & 8'hFE);
                end
                gate_c = 0;
                low_c  = 1;
            end else if (busy) begin
                if (waveform[0]) gate_c++;
                else low_c++;
            end
            if (done != '0) begin
                done_cnt++;
                chk("done_queued", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    chk("done_onehot", done, 32'(1 << d.id));
                    chk("gate_cycles", gate_c, d.gate);
                    chk("low_cycles", low_c, d.low);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        req           = '0;
        kill          = 1'b0;
        req_frequency = '0;
        req_duration  = '0;
        req_attack    = '0;
        req_sustain   = '0;
        req_waveform  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_frequency", frequency, 0);
        chk("rst_waveform", waveform, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        rst_n = 1'b1;

        // All requesters held: rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_note(i, 16'(16'h1000 + i * 16'h0111), 8'd1, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) expect_note(i % NREQ, 1, 1'b1);
        req = 4'b1111;
        wait_acks(na, 100, lat);
        req = '0;
        wait_dones(nd, 30);
        @(negedge clk);
        #1;
        chk("rot_idle_busy", busy, 0);

        // Single note on requester 1, duration 3.
        set_note(1, 16'h1234, 8'd3, 8'h41);
        expect_note(1, 3, 1'b1);
        req = 4'b0010;
        wait_acks(na, 10, lat);
        chk("ack_latency", lat, 1);
        req = '0;
        wait_dones(nd, 40);
        @(negedge clk);
        #1;
        chk("after_done_busy", busy, 0);
        chk("after_done_gate", waveform[0], 0);
        chk("after_done_done", done, 0);

        // Zero duration goes straight to release.
        set_note(2, 16'hBEEF, 8'd0, 8'h81);
        expect_note(2, 0, 1'b1);
        req = 4'b0100;
        wait_acks(na, 10, lat);
        req = '0;
        wait_dones(nd, 30);

        // Kill five cycles into GATE; pointer still advances to requester 3.
        set_note(3, 16'h0F0F, 8'd3, 8'h21);
        expect_note(3, 3, 1'b0);
        req = 4'b1000;
        wait_acks(na, 10, lat);
        req = '0;
        repeat (5) @(negedge clk);
        #1;
        chk("kill_pre_gate", waveform[0], 1);
        kill = 1'b1;
        @(negedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", busy, 0);
        chk("kill_gate", waveform[0], 0);
        chk("kill_done", done, 0);
        repeat (3) @(negedge clk);
        set_note(0, 16'h0A0A, 8'd0, 8'h11);
        expect_note(0, 0, 1'b1);
        req = 4'b1001;
        wait_acks(na, 10, lat);
        req = '0;
        wait_dones(nd, 30);

        // Kill together with a request in IDLE is ignored.
        set_note(2, 16'h2222, 8'd0, 8'h31);
        expect_note(2, 0, 1'b1);
        req  = 4'b0100;
        kill = 1'b1;
        @(negedge clk);
        #1;
        kill = 1'b0;
        wait_acks(na, 10, lat);
        req = '0;
        wait_dones(nd, 30);

        // Request arriving in the done cycle waits one IDLE cycle.
        set_note(1, 16'h1111, 8'd0, 8'h51);
        set_note(0, 16'h3333, 8'd0, 8'h61);
        expect_note(1, 0, 1'b1);
        expect_note(0, 0, 1'b1);
        req = 4'b0010;
        wait_acks(na - 1, 10, lat);
        req = '0;
        wait_dones(nd - 1, 30);
        req = 4'b0001;
        @(negedge clk);
        #1;
        chk("gap_idle_busy", busy, 0);
        chk("gap_idle_ack", ack, 0);
        @(negedge clk);
        #1;
        chk("gap_load_ack", ack, 4'b0001);
        req = '0;
        wait_dones(nd, 30);

        // Asynchronous reset mid-GATE abandons the note.
        set_note(2, 16'h4444, 8'd3, 8'h71);
        expect_note(2, 3, 1'b0);
        req = 4'b0100;
        wait_acks(na, 10, lat);
        req = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_frequency", frequency, 0);
        chk("arst_waveform", waveform, 0);
        chk("arst_busy", busy, 0);
        chk("arst_gnt_id", gnt_id, 0);
        chk("arst_ack", ack, 0);
        chk("arst_done", done, 0);
        set_note(3, 16'h5555, 8'd1, 8'h91);
        expect_note(3, 1, 1'b1);
        req = 4'b1000;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_acks(na, 10, lat);
        chk("arst_ack_latency", lat, 1);
        req = '0;
        wait_dones(nd, 30);

        repeat (3) @(negedge clk);
        chk("grant_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
